aes_key_expand: RTL and testbench

- Iterative AES key schedule generator that builds the full round-key word array from a cipher key, one word per clock.
- Sits directly upstream of the pipelined cipher and drives its round-key array input.
- Ready_out gates the cipher's Enable: the cipher must not be enabled while Ready_out is low.
- Shares the SBox table with the cipher; contains no S-box of its own.

---
 rtl/aes_key_expand_if.sv | 43 ++++
 rtl/aes_key_expand.sv | 142 ++++++++++++++
 tb/tb_aes_key_expand.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if
//   Bundles the key-expansion request/result signals between the key
//   schedule generator (slave) and whoever supplies keys and consumes round
//   keys (master).
//
//   Parameter NK : key length in 32-bit words (4, 6 or 8).
//
//   Key_in    : cipher key bytes, byte 0 first (master -> slave)
//   Start     : single-cycle expansion request   (master -> slave)
//   KExp      : round-key words w[0..NB*(NR+1)-1] (slave -> master)
//   Ready_out : KExp holds a complete schedule    (slave -> master)
//   Busy_out  : expansion in progress             (slave -> master)
interface aes_key_expand_if #(
  parameter int NK = 4
) ();

  localparam int NB = 4;
  localparam int NR = NK + 6;
  localparam int NW = NB * (NR + 1);

  logic [7:0]  Key_in [4*NK];
  logic        Start;
  logic [31:0] KExp [NW];
  logic        Ready_out;
  logic        Busy_out;

  modport master (
    output Key_in,
    output Start,
    input  KExp,
    input  Ready_out,
    input  Busy_out
  );

  modport slave (
    input  Key_in,
    input  Start,
    output KExp,
    output Ready_out,
    output Busy_out
  );

endinterface

// File: rtl/aes_key_expand.sv
// aes_key_expand
//   Iterative AES key schedule generator. On Start it loads the cipher key
//   into w[0..NK-1], then computes one further round-key word per clock until
//   w[NB*(NR+1)-1] is written, at which point Ready_out rises. The S-box is
//   not instantiated here; the cipher's table is shared through SBox.
//
//   Parameter NK : key length in words (4, 6, 8 -> AES-128/192/256).
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     SBox : forward S-box table (256 x 8)
//     kif  : aes_key_expand_if slave (Key_in, Start, KExp, Ready_out, Busy_out)
//
//   Build option: define AES_KEXP_CLEAR_EN to zero words w[NK..end] on the
//   load edge so no stale round key from the previous key is visible while
//   expanding. Without it those words hold their old values until rewritten.
module aes_key_expand #(
  parameter int NK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     SBox [256],
  aes_key_expand_if.slave kif
);

  localparam int NB = 4;
  localparam int NR = NK + 6;
  localparam int NW = NB * (NR + 1);
  localparam int IW = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   w [NW];
  logic [IW-1:0] i;
  // j tracks i mod NK as a wrap counter so no divider is needed.
  logic [2:0]    j;
  logic [7:0]    rcon;
  logic          ready_q;
  logic          busy_q;

  logic          last_word;
  logic [31:0]   temp;
  logic [31:0]   new_word;
  logic [7:0]    rcon_next;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBox[x[31:24]], SBox[x[23:16]], SBox[x[15:8]], SBox[x[7:0]]};
  endfunction

  // Next schedule word from w[i-1] and w[i-NK]; only meaningful in EXPAND.
  always_comb begin
    rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    last_word = (i == IW'(NW - 1));
    temp      = w[i - IW'(1)];
    if (j == 3'd0) begin
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
    end else if (NK == 8 && j == 3'd4) begin
      temp = sub_word(temp);
    end
    new_word = w[i - IW'(NK)] ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is only honoured outside EXPAND, so a running expansion always
  // completes unchanged.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (kif.Start) state_next = EXPAND;
      EXPAND:  if (last_word) state_next = DONE;
      DONE:    if (kif.Start) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        w[k] <= '0;
      end
      i       <= '0;
      j       <= '0;
      rcon    <= 8'h01;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (kif.Start) begin
            for (int k = 0; k < NK; k++) begin
              w[k] <= {kif.Key_in[4*k], kif.Key_in[4*k+1],
                       kif.Key_in[4*k+2], kif.Key_in[4*k+3]};
            end
`ifdef AES_KEXP_CLEAR_EN
            for (int k = NK; k < NW; k++) begin
              w[k] <= '0;
            end
`endif
            i       <= IW'(NK);
            j       <= 3'd0;
            rcon    <= 8'h01;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        EXPAND: begin
          w[i] <= new_word;
          i    <= i + IW'(1);
          j    <= (j == 3'(NK - 1)) ? 3'd0 : j + 3'd1;
          if (j == 3'd0) begin
            rcon <= rcon_next;
          end
          if (last_word) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign kif.KExp      = w;
  assign kif.Ready_out = ready_q;
  assign kif.Busy_out  = busy_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand
//   Drives three instances (NK = 4, 6, 8) from a shared key byte array and
//   checks their schedules against an independent key-schedule model and the
//   FIPS-197 reference words. Expected schedules are queued when Start is
//   driven and popped when Ready_out rises.
module tb_aes_key_expand;

  typedef logic [31:0] sched_t [60];

  typedef struct {
    int          nk;
    logic [31:0] words [60];
    int          latency;
  } sb_entry_t;

  typedef struct {
    int          nk;
    logic [31:0] key [8];
    int          ia;
    logic [31:0] wa;
    int          ib;
    logic [31:0] wb;
    int          ic;
    logic [31:0] wc;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sbox [256];
  logic [7:0]  key_bytes [32];
  logic        start_req = 1'b0;
  int          sel = 0;
  logic        cur_ready;
  logic        cur_busy;
  logic [31:0] cur_kexp [60];
  sb_entry_t   sb_q [$];
  int          total = 0;
  int          bad = 0;
  vec_t        vecs [3];
  logic [31:0] probe_kexp [60];
  logic        probe_ready;
  int          probe_edge = 0;
  logic [7:0]  rcon_tab [10];

  always #5 clk = ~clk;

  aes_key_expand_if #(.NK(4)) if4 ();
  aes_key_expand_if #(.NK(6)) if6 ();
  aes_key_expand_if #(.NK(8)) if8 ();

  aes_key_expand #(.NK(4)) dut4 (.clk(clk), .rst(rst), .SBox(sbox), .kif(if4));
  aes_key_expand #(.NK(6)) dut6 (.clk(clk), .rst(rst), .SBox(sbox), .kif(if6));
  aes_key_expand #(.NK(8)) dut8 (.clk(clk), .rst(rst), .SBox(sbox), .kif(if8));

  // Key bytes fan out to all instances; Start only reaches the selected one.
  always_comb begin
    for (int k = 0; k < 16; k++) if4.Key_in[k] = key_bytes[k];
    for (int k = 0; k < 24; k++) if6.Key_in[k] = key_bytes[k];
    for (int k = 0; k < 32; k++) if8.Key_in[k] = key_bytes[k];
    if4.Start = start_req && (sel == 0);
    if6.Start = start_req && (sel == 1);
    if8.Start = start_req && (sel == 2);
  end

  always_comb begin
    cur_ready = 1'b0;
    cur_busy  = 1'b0;
    for (int k = 0; k < 60; k++) cur_kexp[k] = '0;
    case (sel)
      0: begin
        cur_ready = if4.Ready_out;
        cur_busy  = if4.Busy_out;
        for (int k = 0; k < 44; k++) cur_kexp[k] = if4.KExp[k];
      end
      1: begin
        cur_ready = if6.Ready_out;
        cur_busy  = if6.Busy_out;
        for (int k = 0; k < 52; k++) cur_kexp[k] = if6.KExp[k];
      end
      default: begin
        cur_ready = if8.Ready_out;
        cur_busy  = if8.Busy_out;
        for (int k = 0; k < 60; k++) cur_kexp[k] = if8.KExp[k];
      end
    endcase
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // S-box from the GF(2^8) inverse plus the affine transform.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) begin
          inv = 8'(y);
          break;
        end
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic modelExpand(input int nk, output sched_t ws);
    int          nw;
    logic [31:0] t;
    for (int k = 0; k < 60; k++) ws[k] = '0;
    for (int k = 0; k < nk; k++)
      ws[k] = {key_bytes[4*k], key_bytes[4*k+1], key_bytes[4*k+2], key_bytes[4*k+3]};
    nw = 4 * (nk + 7);
    for (int n = nk; n < nw; n++) begin
      t = ws[n-1];
      if (n % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[n/nk - 1], 24'h0};
      else if (nk == 8 && n % nk == 4)
        t = subw(t);
      ws[n] = ws[n-nk] ^ t;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setKey(input logic [31:0] kw [8]);
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 4; b++)
        key_bytes[4*k+b] = kw[k][31-8*b -: 8];
  endtask

  task automatic applyStimulus(input int s, input bit push, input int lat);
    sb_entry_t e;
    sched_t    tmp;
    sel = s;
    if (push) begin
      e.nk = 4 + 2 * s;
      modelExpand(e.nk, tmp);
      e.words   = tmp;
      e.latency = lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_req = 1'b1;
  endtask

  // Counts edges from the Start edge until Ready_out, bounded at 200.
  task automatic waitReady(input int restart_at, input int scramble_at,
                           output int edges, output int busy_err);
    edges    = 0;
    busy_err = 0;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) start_req = 1'b0;
      if (edges == restart_at) start_req = 1'b1;
      if (edges == restart_at + 1) start_req = 1'b0;
      if (edges == scramble_at)
        for (int k = 0; k < 32; k++) key_bytes[k] = 8'($urandom);
      if (edges == probe_edge) begin
        probe_ready = cur_ready;
        for (int k = 0; k < 60; k++) probe_kexp[k] = cur_kexp[k];
      end
      if (cur_busy !== ~cur_ready) busy_err++;
      if (cur_ready === 1'b1) break;
    end
  endtask

  task automatic checkOutput(input string tag, input int edges, input int busy_err);
    sb_entry_t e;
    int        nw;
    int        diff;
    int        first;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    checkVal({tag, " latency"}, 32'(edges), 32'(e.latency));
    checkVal({tag, " busy complement errors"}, 32'(busy_err), 32'd0);
    nw    = 4 * (e.nk + 7);
    diff  = 0;
    first = -1;
    for (int k = 0; k < nw; k++) begin
      if (cur_kexp[k] !== e.words[k]) begin
        diff++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (diff != 0) begin
      bad++;
      $display("[TB] FAIL %s schedule: %0d words differ, w[%0d] got %h expected %h",
               tag, diff, first, cur_kexp[first], e.words[first]);
    end
  endtask

  task automatic checkAllZero(input string name);
    int nz;
    nz = 0;
    for (int k = 0; k < 60; k++) if (cur_kexp[k] !== 32'h0) nz++;
    checkVal(name, 32'(nz), 32'd0);
  endtask

  initial begin
    int          edges;
    int          busy_err;
    logic [31:0] exp43;
    logic [31:0] b_word0;
    sched_t      b_sched;

    buildSbox();
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    vecs[0] = '{nk: 4,
                key: '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                       32'h0, 32'h0, 32'h0, 32'h0},
                ia: 4, wa: 32'ha0fafe17, ib: 43, wb: 32'hb6630ca6,
                ic: 7, wc: 32'h2a6c7605, lat: 41};
    vecs[1] = '{nk: 6,
                key: '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                       32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0},
                ia: 6, wa: 32'hfe0c91f7, ib: 51, wb: 32'h01002202,
                ic: 7, wc: 32'h2402f5a5, lat: 47};
    vecs[2] = '{nk: 8,
                key: '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                       32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4},
                ia: 8, wa: 32'h9ba35411, ib: 12, wb: 32'ha8b09c1a,
                ic: 59, wc: 32'h706c631e, lat: 53};

    for (int k = 0; k < 32; k++) key_bytes[k] = 8'h00;

    // Reset state of every instance.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkVal("reset ready", 32'(cur_ready), 32'd0);
      checkVal("reset busy", 32'(cur_busy), 32'd0);
      checkAllZero("reset kexp nonzero words");
    end
    rst = 1'b0;

    // FIPS-197 vectors for each key size.
    for (int v = 0; v < 3; v++) begin
      setKey(vecs[v].key);
      applyStimulus((vecs[v].nk - 4) / 2, 1'b1, vecs[v].lat);
      waitReady(0, 0, edges, busy_err);
      checkOutput($sformatf("nk%0d", vecs[v].nk), edges, busy_err);
      checkVal($sformatf("nk%0d w[%0d]", vecs[v].nk, vecs[v].ia), cur_kexp[vecs[v].ia], vecs[v].wa);
      checkVal($sformatf("nk%0d w[%0d]", vecs[v].nk, vecs[v].ib), cur_kexp[vecs[v].ib], vecs[v].wb);
      checkVal($sformatf("nk%0d w[%0d]", vecs[v].nk, vecs[v].ic), cur_kexp[vecs[v].ic], vecs[v].wc);
    end

    // Key_in scrambled at edge 5 and Start re-pulsed at edge 10: both ignored.
    setKey(vecs[0].key);
    applyStimulus(0, 1'b1, 41);
    waitReady(10, 5, edges, busy_err);
    checkOutput("restart ignored", edges, busy_err);
    checkVal("restart ignored w[43]", cur_kexp[43], 32'hb6630ca6);

    // Reset in the middle of an expansion.
    setKey(vecs[0].key);
    applyStimulus(0, 1'b0, 41);
    for (int e = 1; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) start_req = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("abort ready", 32'(cur_ready), 32'd0);
    checkVal("abort busy", 32'(cur_busy), 32'd0);
    checkAllZero("abort kexp nonzero words");
    repeat (5) @(posedge clk);
    #1;
    checkVal("abort stays idle busy", 32'(cur_busy), 32'd0);
    applyStimulus(0, 1'b1, 41);
    waitReady(0, 0, edges, busy_err);
    checkOutput("after abort", edges, busy_err);

    // From DONE with key A, start key B; probe just before w[43] is rewritten.
    for (int k = 0; k < 16; k++) key_bytes[k] = 8'($urandom);
    b_word0 = {key_bytes[0], key_bytes[1], key_bytes[2], key_bytes[3]};
    probe_edge = 40;
    applyStimulus(0, 1'b1, 41);
    b_sched = sb_q[0].words;
    waitReady(0, 0, edges, busy_err);
    probe_edge = 0;
    checkOutput("key B", edges, busy_err);
`ifdef AES_KEXP_CLEAR_EN
    exp43 = 32'h0;
`else
    exp43 = 32'hb6630ca6;
`endif
    checkVal("key B probe ready", 32'(probe_ready), 32'd0);
    checkVal("key B probe w[43]", probe_kexp[43], exp43);
    checkVal("key B probe w[0]", probe_kexp[0], b_word0);
    checkVal("key B probe w[42]", probe_kexp[42], b_sched[42]);

    // DONE holds.
    repeat (5) @(posedge clk);
    #1;
    checkVal("done hold ready", 32'(cur_ready), 32'd1);
    checkVal("done hold busy", 32'(cur_busy), 32'd0);
    checkVal("done hold w[43]", cur_kexp[43], b_sched[43]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
